// File: rtl/uart_loader_if.sv
// RAM write-port bundle driven by uart_loader: write strobe, word address and write data.
interface uart_loader_if #(
  parameter int WIDTH = 32
);
  logic             wram;
  logic [WIDTH-1:0] ramaddress;
  logic [WIDTH-1:0] wramdata;

  modport master (output wram, ramaddress, wramdata);
  modport slave  (input  wram, ramaddress, wramdata);
endinterface

// File: rtl/uart_loader.sv
// UART receiver that packs little-endian byte quads into 32-bit words and writes them to RAM.
// Define UART_LOADER_PARITY_EN for 8E1 framing with a PARITY state; otherwise frames are 8N1.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for rx low
// S_START  | timing to mid start bit, rejecting glitches
// S_DATA   | sampling 8 data bits LSB first
// S_PARITY | sampling the even-parity bit (parity build only)
// S_STOP   | sampling stop bit, accepting or discarding the byte
module uart_loader #(
  parameter int          WIDTH        = 32,
  parameter int          CLKS_PER_BIT = 16,
  parameter int unsigned BASEADDR     = 0,
  parameter int          WORDS        = 4096
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          datai,
  uart_loader_if.master ram,
  output logic          busy,
  output logic          done,
  output logic          ferr
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(WORDS + 1);
  localparam logic [TW-1:0] HALF_TC  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_TC  = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_LOADER_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_q, rx_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [1:0]       lane_q, lane_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             wram_q, wram_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             full;
  logic             par_bad;

`ifdef UART_LOADER_PARITY_EN
  logic par_q, par_d;
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  // Once all words are written, framing continues but lane/idx freeze.
  assign full = (idx_q == IDX_LAST);

  always_comb begin
    state_d   = state_q;
    rx_meta_d = datai;
    rx_d      = rx_meta_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    lane_d    = lane_q;
    word_d    = word_q;
    idx_d     = idx_q;
    wram_d    = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ferr_d    = 1'b0;
    done_d    = done_q | full;
`ifdef UART_LOADER_PARITY_EN
    par_d     = par_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!rx_q) begin
          state_d = S_START;
          tick_d  = HALF_TC;
        end
      end

      S_START: begin
        if (tick_q == '0) begin
          if (!rx_q) begin
            state_d = S_DATA;
            tick_d  = FULL_TC;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end

      S_DATA: begin
        if (tick_q == '0) begin
          shift_d = {rx_q, shift_q[7:1]};
          tick_d  = FULL_TC;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end

`ifdef UART_LOADER_PARITY_EN
      S_PARITY: begin
        if (tick_q == '0) begin
          par_d   = rx_q;
          tick_d  = FULL_TC;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (tick_q == '0) begin
          state_d = S_IDLE;
          if (!rx_q || par_bad) begin
            ferr_d = 1'b1;
          end else if (!full) begin
            word_d[{lane_q, 3'b000} +: 8] = shift_q;
            lane_d = lane_q + 1'b1;
            // Lane 3 completes the word: issue the write straight from the new byte.
            if (lane_q == 2'd3) begin
              wram_d  = 1'b1;
              addr_d  = WIDTH'(BASEADDR) + WIDTH'(idx_q);
              wdata_d = {shift_q, word_q[WIDTH-9:0]};
              idx_d   = idx_q + 1'b1;
            end
          end
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      lane_q    <= '0;
      word_q    <= '0;
      idx_q     <= '0;
      wram_q    <= 1'b0;
      addr_q    <= WIDTH'(BASEADDR);
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_LOADER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_q      <= rx_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      wram_q    <= wram_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_LOADER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign ram.wram       = wram_q;
  assign ram.ramaddress = addr_q;
  assign ram.wramdata   = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign ferr           = ferr_q;

endmodule

// File: doc/uart_loader.md
# uart_loader

Serial-to-RAM loader for the JPEG encoding SoC. It receives 8N1 UART bytes on `datai` and packs each group of four bytes, little-endian, into one 32-bit word. Each completed word is written through the second RAM write port (the port the core does not drive), at consecutive word addresses from `BASEADDR`. The core polls `done` and then encodes the image the loader has placed in RAM.

## Interface
- `WIDTH`, 32: data and address width; must be 32.
- `CLKS_PER_BIT`, 16: `clk` cycles per UART bit; must be ≥ 4 and even.
- `BASEADDR`, 0: word address of the first write.
- `WORDS`, 4096: number of words to load before `done` asserts; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `nrst` in 1: synchronous, active-low reset.
- `datai` in 1: asynchronous UART RX line; idles high.
- `wram` out 1: RAM write strobe; one-cycle pulse.
- `ramaddress` out WIDTH: RAM word address.
- `wramdata` out WIDTH: RAM write data.
- `busy` out 1: high while a frame is being received.
- `done` out 1: sticky; high once `WORDS` words are written.
- `ferr` out 1: one-cycle pulse on framing or parity error.

## Operation
- `datai` passes through a 2-flop synchronizer, reset value 1. All receive logic uses the synchronized signal `rx`.
- Receive FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE → START:
  - On `rx`=0, clear the tick counter.
- START:
  - At tick `CLKS_PER_BIT/2-1` (mid start bit), if `rx`=0, go to DATA with the tick counter cleared.
  - Otherwise go back to IDLE (false start, no error).
- DATA:
  - Sample `rx` at tick `CLKS_PER_BIT-1` of each bit, LSB first, into the byte shift register.
  - After bit index 7, go to STOP (or PARITY).
- STOP:
  - Sample at tick `CLKS_PER_BIT-1`.
  - If 1, the byte is valid.
  - If 0, pulse `ferr` and discard the byte.
  - Return to IDLE either way.
- Packing:
  - A valid byte goes into lane `lane` of the word register, bits `[8*lane+7:8*lane]`, and `lane` increments mod 4.
  - When lane 3 is filled, the word is complete.
  - Discarded bytes do not advance `lane`.
- Write:
  - On the cycle after a word completes, `wram`=1 for exactly one cycle, with `ramaddress`=`BASEADDR+idx` and `wramdata`=the packed word.
  - `idx` then increments.
  - `ramaddress` and `wramdata` hold their last values between writes.
- Completion:
  - When `idx` reaches `WORDS`, `done`=1 until reset.
  - The FSM keeps framing bytes (so `ferr` stays reported), but no further writes occur and `lane`/`idx` freeze.
- `busy`=1 in every state except IDLE.
- The RAM accepts writes every cycle, so there is no back-pressure.

## Timing
- Reset values: `wram`=0, `ramaddress`=`BASEADDR`, `wramdata`=0, `busy`=0, `done`=0, `ferr`=0; FSM in IDLE, `lane`=0, `idx`=0, tick counter 0.
- Reset is synchronous. Asserting `nrst` mid-frame discards any partial byte and partial word on the next edge; no write is issued.
- The START decision comes `CLKS_PER_BIT/2` cycles after the synchronized falling edge. Each subsequent bit sample follows the previous one by exactly `CLKS_PER_BIT` cycles.
- Latency: `wram` rises 1 cycle after the stop-bit sample of the 4th byte, and 2+1 cycles after that byte's stop-bit mid-point on raw `datai`, counting the synchronizer.
- `ferr` rises 1 cycle after the failing sample.
- `done` rises in the same cycle that `wram` falls after the final write.
- Back-to-back frames: the FSM is in IDLE from the cycle after the stop sample, so a start bit that directly follows a stop bit is caught.
- Counter widths: tick counter is `$clog2(CLKS_PER_BIT)`, bit index is 3 bits, `lane` is 2 bits, `idx` is `$clog2(WORDS+1)`. Address arithmetic is WIDTH bits and wraps modulo 2^32.

## Configuration
- `UART_LOADER_PARITY_EN` defined:
  - Frames are 8E1. The PARITY state samples one extra bit, `CLKS_PER_BIT` after bit 7.
  - If the XOR of the 8 data bits and the parity bit is 1, pulse `ferr` in STOP and discard the byte, even if the stop bit is good.
- Undefined: frames are 8N1, there is no PARITY state, and only stop-bit errors set `ferr`.

## Test plan
- Reset values: `CLKS_PER_BIT`=16, `BASEADDR`=0x100, `WORDS`=4. After reset, all outputs equal their reset values and `ramaddress`=0x100.
- Single word: send bytes 0x11, 0x22, 0x33, 0x44 → exactly one `wram` pulse, with `ramaddress`=0x100 and `wramdata`=0x44332211.
- False start: 4-cycle low glitch on `datai` → FSM returns to IDLE, no `ferr`. Then send 0xA5 → it is placed in lane 0.
- Bad stop bit: frame 0x5A with stop bit 0 → `ferr` one-cycle pulse, `lane` unchanged. Then 4 good bytes → one write of those 4 bytes only.
- Completion: send 20 bytes 0x00..0x13 → 4 writes at 0x100..0x103, last data 0x0F0E0D0C, `done`=1, no 5th write.
- Reset mid-operation, then parity:
  - Assert `nrst` after 2 bytes plus half of a 3rd → all state cleared. Then 4 new bytes → write at 0x100.
  - With `UART_LOADER_PARITY_EN`, send 0x01 with parity 0 → `ferr`.
